// File: rtl/ssd_score_display.sv
// Multiplexed common-anode seven-segment driver: sequential double-dabble
// binary-to-BCD conversion into a double-buffered display register, with blanking/blink/overflow.
module ssd_score_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned BIN_WIDTH   = 14,
  parameter int unsigned REFRESH_DIV = 131072,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                  board_clk,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  value_in,
  input  logic                  value_load,
  input  logic                  blank_zeros,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [7:0]            seg_n
);

  localparam int unsigned DW    = 4 * NUM_DIGITS;
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] max_value(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'b00000011;
      4'd1:    return 8'b10011111;
      4'd2:    return 8'b00100101;
      4'd3:    return 8'b00001101;
      4'd4:    return 8'b10011001;
      4'd5:    return 8'b01001001;
      4'd6:    return 8'b01000001;
      4'd7:    return 8'b00011111;
      4'd8:    return 8'b00000001;
      4'd9:    return 8'b00001001;
      default: return 8'b11111111;
    endcase
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [BIN_WIDTH-1:0]  shift_q, shift_d;
  logic [DW-1:0]         work_q, work_d, disp_q, disp_d, adj;
  logic [CNT_W-1:0]      iter_q, iter_d;
  logic                  ovf_pend_q, ovf_pend_d, overflow_q, overflow_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic                  phase_q, phase_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic [3:0]            nib;
  logic                  blank;

  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3 : work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    case (state_q)
      IDLE: begin
        if (value_load) begin
          shift_d    = value_in;
          work_d     = '0;
          iter_d     = CNT_W'(BIN_WIDTH);
          ovf_pend_d = 64'(value_in) > MAX_VAL;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, shift_d} = {adj[DW-2:0], shift_q, 1'b0};
        iter_d = iter_q - CNT_W'(1);
        // the final shift result goes straight into the display buffer
        if (iter_q == CNT_W'(1)) begin
          disp_d     = work_d;
          overflow_d = ovf_pend_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ref_d   = (ref_q == REF_W'(REFRESH_DIV - 1)) ? '0 : ref_q + REF_W'(1);
    dig_d   = dig_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      dig_d = (dig_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end
    blk_d   = (blk_q == BLK_W'(BLINK_DIV - 1)) ? '0 : blk_q + BLK_W'(1);
    phase_d = (blk_q == BLK_W'(BLINK_DIV - 1)) ? ~phase_q : phase_q;

    nib   = '0;
    blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == DIG_W'(i)) begin
        nib   = disp_q[4*i +: 4];
        blank = blank_zeros && (i != 0) && ((disp_q >> (4*i)) == '0);
      end
    end

    an_d  = ~(NUM_DIGITS'(1) << dig_q);
    seg_d = seg_decode(nib);
    if (overflow_q) begin
      seg_d = 8'b11111101;
    end else if (blank) begin
      an_d  = '1;
      seg_d = 8'b11111111;
    end
    if (blink_en && phase_q) an_d = '1;
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
      ref_q      <= '0;
      blk_q      <= '0;
      phase_q    <= 1'b0;
      dig_q      <= '0;
      an_q       <= '1;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      ref_q      <= ref_d;
      blk_q      <= blk_d;
      phase_q    <= phase_d;
      dig_q      <= dig_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign overflow = overflow_q;
  assign an_n     = an_q;
  assign seg_n    = seg_q;

endmodule
